i2s_tx: RTL
===========

# i2s_tx

Serializes the WSG's stereo output (`o_Aud_Left` / `o_Aud_Right`, 16-bit signed, one new pair every 256 audio clocks) onto a standard Philips I2S link for the board DAC. It runs entirely in the audio clock domain, downstream of the WSG.
- Generates BCLK, LRCLK and SDATA with a 64-BCLK frame.
- Captures one sample pair per frame.
- Applies a click-free soft-mute gain ramp before serialization.

## Interface
- `p_Bclk_Half`, default 2: audio clocks per BCLK half-period. Frame length = 128·`p_Bclk_Half` clocks (256 at default, i.e. 48 kHz from 12.288 MHz). Legal values are ≥1.
- `i_Audio_Clk`  in  1  sole clock, 12.288 MHz.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Aud_Left`  in  16  signed left sample; connects to WSG `o_Aud_Left`.
- `i_Aud_Right`  in  16  signed right sample; connects to WSG `o_Aud_Right`.
- `i_Mute`  in  1  1 = ramp gain to 0; 0 = ramp gain to unity.
- `o_I2S_BCLK`  out  1  bit clock.
- `o_I2S_LRCLK`  out  1  word select: 0 = left, 1 = right.
- `o_I2S_SDATA`  out  1  serial data, MSB first.
- `o_Frame_Start`  out  1  one-cycle pulse on the first cycle of each frame.
- `o_Muted`  out  1  high while gain == 0.

## Operation
- **Counters**
  - Prescaler `div` runs 0..`p_Bclk_Half`-1. On wrap, BCLK toggles.
  - Slot counter runs 0..63. It advances on every BCLK falling edge and wraps 63→0.
- **Outputs**
  - All outputs are registered.
  - BCLK, LRCLK and SDATA change only in the cycle in which BCLK goes low.
- **LRCLK**
  - LRCLK = 1 for slots 32..63 and 0 otherwise.
- **SDATA (one-BCLK I2S delay)**
  - Slot 0: 0.
  - Slots 1..16: left bits 15..0.
  - Slots 17..32: 0.
  - Slots 33..48: right bits 15..0.
  - Slots 49..63: 0.
- **Capture, at the final clock of slot 63**
  - Left shadow ← (`i_Aud_Left` · gain) >>> 8, and the same for right with `i_Aud_Right`.
  - The product is 25-bit signed; the shift is arithmetic and the result is truncated to 16 bits.
  - The old gain is used for the capture.
  - Both channels sample the inputs in the same cycle.
  - The inputs are otherwise ignored, so mid-frame changes do not affect the frame being sent.
- **Gain (9 bits, 0..256)**
  - Steps once per frame, on the capture edge.
  - If `i_Mute`=0 and gain<256, gain increments by 1.
  - If `i_Mute`=1 and gain>0, gain decrements by 1.
  - Otherwise gain holds.
  - Toggling `i_Mute` mid-ramp reverses direction from the current value.
  - Full ramp takes 256 frames (5.33 ms).
  - gain = 256 is exact passthrough.
- **`o_Muted`**
  - Registered as (next gain == 0).

## Timing
- **Reset values** (one cycle after `i_Reset` is sampled high):
  - BCLK = 0, LRCLK = 0, SDATA = 0, `o_Frame_Start` = 0, `o_Muted` = 1.
  - gain = 0; shadows = 0; `div` = 0; slot = 0.
- **Reset mid-frame:** abandons the frame; there is no partial-word completion. The first frame after release is fully aligned.
- **Cycle numbering:** n = cycles since reset release, default `p_Bclk_Half` = 2.
  - BCLK is high when ⌊n/2⌋ is odd.
  - slot = ⌊n/4⌋ mod 64.
  - Frame boundary at n mod 256 = 0.
- **Frame start:** `o_Frame_Start` = 1 exactly when n mod 256 = 0 and n > 0. It is not asserted at the first cycle after reset.
- **First frame:** all zeros, because the shadows are in reset.
- **Latency:** input present at clock n≡255 → MSB on SDATA at slot 1, i.e. 4 clocks later (2·`p_Bclk_Half`). Right-channel MSB follows 128 clocks after that.
- **Setup/hold for the DAC:** data is stable for a full BCLK high phase, since data changes on the falling edge and is sampled on the rising edge.

## Test plan
- **Reset:** assert `i_Reset` mid-frame (slot 40) → next cycle shows BCLK=0, LRCLK=0, SDATA=0, `o_Muted`=1. After release, `o_Frame_Start` first pulses at n=256.
- **Ramp up:** `i_Mute`=0, inputs L=0x4000, R=0xC000 held.
  - Frame captured with gain 128 serializes L=0x2000, R=0xE000.
  - `o_Muted` falls after the first frame boundary.
- **Unity passthrough:** after ≥257 frames, L=0x8001, R=0x7FFE → decoded bits are exactly 0x8001 / 0x7FFE. Slots 0, 17..32 and 49..63 read 0. LRCLK toggles at slots 0 and 32.
- **Mute reversal:** ramp to gain 100, assert `i_Mute` → gain decreases 99, 98, …. Release at gain 50 → gain climbs again. With L=0x7FFF, serialized values are monotonic with no step larger than 0x80.
- **Capture isolation:** change `i_Aud_Left` from 0x1234 to 0x5678 at slot 10 → current frame sends 0x1234 and the next frame sends 0x5678 (at unity gain).
- **Negative extreme:** L=0x8000 at gain 128 → 0xC000 serialized. At gain 256 → 0x8000. At gain 0 → 0x0000 and `o_Muted`=1.

Source files
------------

// File: rtl/i2s_tx.sv
// Philips I2S transmitter with a 64-BCLK frame. One stereo pair is captured per frame
// and scaled by a per-frame soft-mute gain ramp (0..256, 256 = exact passthrough).
module i2s_tx #(
  parameter int p_Bclk_Half = 2
) (
  input  logic        i_Audio_Clk,
  input  logic        i_Reset,
  input  logic [15:0] i_Aud_Left,
  input  logic [15:0] i_Aud_Right,
  input  logic        i_Mute,
  output logic        o_I2S_BCLK,
  output logic        o_I2S_LRCLK,
  output logic        o_I2S_SDATA,
  output logic        o_Frame_Start,
  output logic        o_Muted
);

  localparam int DIV_W = (p_Bclk_Half > 1) ? $clog2(p_Bclk_Half) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(p_Bclk_Half - 1);

  logic [DIV_W-1:0]   div;
  logic [5:0]         slot;
  logic [5:0]         slot_next;
  logic [8:0]         gain;
  logic [8:0]         gain_next;
  logic [15:0]        left_sh;
  logic [15:0]        right_sh;
  logic [15:0]        left_cap;
  logic [15:0]        right_cap;
  logic               div_wrap;
  logic               bclk_fall;
  logic               capture;
  logic               sdata_next;
  logic signed [23:0] left_ext;
  logic signed [23:0] right_ext;
  logic signed [23:0] gain_ext;
  logic signed [23:0] left_prod;
  logic signed [23:0] right_prod;

  always_comb begin
    div_wrap  = (div == DIV_LAST);
    bclk_fall = div_wrap && o_I2S_BCLK;
    slot_next = slot + 6'd1;
    capture   = bclk_fall && (slot == 6'd63);

    gain_next = gain;
    if (!i_Mute && (gain != 9'd256))
      gain_next = gain + 9'd1;
    else if (i_Mute && (gain != 9'd0))
      gain_next = gain - 9'd1;

    // |sample * gain| <= 2^23, so a 24-bit signed product is exact
    left_ext   = 24'(signed'(i_Aud_Left));
    right_ext  = 24'(signed'(i_Aud_Right));
    gain_ext   = 24'(gain);
    left_prod  = left_ext * gain_ext;
    right_prod = right_ext * gain_ext;
    left_cap   = 16'(left_prod >>> 8);
    right_cap  = 16'(right_prod >>> 8);

    // Data for the slot being entered: one-BCLK I2S delay after the LRCLK edge
    sdata_next = 1'b0;
    if ((slot_next >= 6'd1) && (slot_next <= 6'd16))
      sdata_next = left_sh[4'(6'd16 - slot_next)];
    else if ((slot_next >= 6'd33) && (slot_next <= 6'd48))
      sdata_next = right_sh[4'(6'd48 - slot_next)];
  end

  always_ff @(posedge i_Audio_Clk) begin
    if (i_Reset) begin
      div           <= '0;
      slot          <= '0;
      gain          <= '0;
      left_sh       <= '0;
      right_sh      <= '0;
      o_I2S_BCLK    <= 1'b0;
      o_I2S_LRCLK   <= 1'b0;
      o_I2S_SDATA   <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Muted       <= 1'b1;
    end else begin
      o_Frame_Start <= 1'b0;

      if (div_wrap) begin
        div        <= '0;
        o_I2S_BCLK <= ~o_I2S_BCLK;
      end else begin
        div <= div + DIV_W'(1);
      end

      if (bclk_fall) begin
        slot          <= slot_next;
        o_I2S_LRCLK   <= slot_next[5];
        o_I2S_SDATA   <= sdata_next;
        o_Frame_Start <= (slot_next == 6'd0);
      end

      // Capture uses the pre-step gain; the step lands on the same edge
      if (capture) begin
        left_sh  <= left_cap;
        right_sh <= right_cap;
        gain     <= gain_next;
        o_Muted  <= (gain_next == 9'd0);
      end
    end
  end

endmodule
